// File: rtl/sd_sig_scanner.sv
// Scans SD blocks from START_BLOCK for a signature at offset 0 and streams the first
// matching block out over valid/ready. Define SD_READ_TIMEOUT_EN to enable the READ watchdog.
module sd_sig_scanner #(
  parameter int unsigned  START_BLOCK    = 8192,
  parameter int unsigned  MAX_BLOCKS     = 1024,
  parameter int unsigned  SIG_LEN        = 8,
  parameter logic [127:0] SIGNATURE      = 128'h444C41425F544142,
  parameter int unsigned  BLOCK_BYTES    = 512,
  parameter bit           STOP_ON_NUL    = 1'b1,
  parameter int unsigned  TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        init_finish,
  output logic        rd_req,
  output logic [31:0] block_address,
  input  logic [7:0]  sd_dout,
  input  logic        sd_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] match_addr,
  output logic        error
);

  localparam int AW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int CW = AW + 1;
  localparam int SW = (SIG_LEN > 1) ? $clog2(SIG_LEN) : 1;

  localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCK_BYTES - 1);
  localparam logic [CW-1:0] SIG_END   = CW'(SIG_LEN);
  localparam logic [31:0]   FIRST_BLK = 32'(START_BLOCK);
  localparam logic [31:0]   LAST_BLK  = 32'(MAX_BLOCKS - 1);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DUMP  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  if (SIG_LEN == 0 || SIG_LEN > 16 || SIG_LEN > BLOCK_BYTES || MAX_BLOCKS == 0 ||
      TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("sd_sig_scanner: illegal parameter combination");
  end

  logic [2:0]    state;
  logic [CW-1:0] byte_cnt;
  logic [AW-1:0] byte_idx;
  logic [31:0]   blk_cnt;
  logic          sig_ok;
  logic          fetched;
  logic          buf_we;
  logic          buf_re;
  logic [7:0]    buffer [BLOCK_BYTES];
  logic [7:0]    sig_rom [SIG_LEN];

  // Signature byte 0 is the most significant of the SIG_LEN used bytes.
  for (genvar g = 0; g < SIG_LEN; g++) begin : g_sig
    assign sig_rom[g] = SIGNATURE[8*(SIG_LEN-1-g) +: 8];
  end

  assign byte_idx = byte_cnt[AW-1:0];
  assign rd_req   = (state == S_REQ);
  assign done     = (state == S_DONE);
  assign busy     = !(state inside {S_INIT, S_IDLE, S_DONE});
  // A fetched NUL is swallowed here so it is never presented to the consumer.
  assign tx_valid = (state == S_DUMP) && fetched && !(STOP_ON_NUL && tx_data == 8'h00);
  assign buf_we   = reset && (state == S_READ) && sd_valid;
  assign buf_re   = (state == S_DUMP) && !fetched;

  // NOTE: the block buffer is deliberately left out of reset so it maps onto block RAM;
  // every byte is rewritten in READ before DUMP can fetch it.
  always_ff @(posedge clk) begin
    if (buf_we) buffer[byte_idx] <= sd_dout;
    if (buf_re) tx_data <= buffer[byte_idx];
  end

`ifdef SD_READ_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] read_timer;
`else
  assign error = 1'b0;
`endif

  // NOTE: all state below updates with non-blocking assignments so every branch sees
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_INIT;
      block_address <= FIRST_BLK;
      match_addr    <= '0;
      found         <= 1'b0;
      byte_cnt      <= '0;
      blk_cnt       <= '0;
      sig_ok        <= 1'b0;
      fetched       <= 1'b0;
`ifdef SD_READ_TIMEOUT_EN
      error         <= 1'b0;
      read_timer    <= '0;
`endif
    end else begin
      case (state)
        S_INIT: if (init_finish) state <= S_IDLE;
        S_IDLE: if (start) begin
          found         <= 1'b0;
          blk_cnt       <= '0;
          block_address <= FIRST_BLK;
`ifdef SD_READ_TIMEOUT_EN
          error         <= 1'b0;
`endif
          state         <= S_REQ;
        end
        S_REQ: begin
          sig_ok   <= 1'b1;
          byte_cnt <= '0;
`ifdef SD_READ_TIMEOUT_EN
          read_timer <= '0;
`endif
          state    <= S_READ;
        end
        S_READ: begin
          if (sd_valid) begin
            if (byte_cnt < SIG_END && sd_dout != sig_rom[byte_cnt[SW-1:0]]) sig_ok <= 1'b0;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_BYTE) state <= S_CHECK;
          end
`ifdef SD_READ_TIMEOUT_EN
          if (sd_valid) begin
            read_timer <= '0;
          end else if (read_timer == TO_LAST) begin
            error <= 1'b1;
            found <= 1'b0;
            state <= S_DONE;
          end else begin
            read_timer <= read_timer + 1'b1;
          end
`endif
        end
        S_CHECK: begin
          if (sig_ok) begin
            found      <= 1'b1;
            match_addr <= block_address;
            byte_cnt   <= '0;
            fetched    <= 1'b0;
            state      <= S_DUMP;
          end else if (blk_cnt == LAST_BLK) begin
            state <= S_DONE;
          end else begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          block_address <= block_address + 32'd1;
          blk_cnt       <= blk_cnt + 32'd1;
          state         <= S_REQ;
        end
        S_DUMP: begin
          if (!fetched) begin
            fetched <= 1'b1;
          end else if (STOP_ON_NUL && tx_data == 8'h00) begin
            state <= S_DONE;
          end else if (tx_ready) begin
            fetched <= 1'b0;
            if (byte_cnt == LAST_BYTE) state <= S_DONE;
            else byte_cnt <= byte_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sig_scanner.sv
// Bench for sd_sig_scanner: two instances (NUL-terminated and full-block dump) share one
// SD/consumer model; results are compared with a block-level reference computed here.
module tb_sd_sig_scanner;

  localparam int          BB   = 512;
  localparam int          NBLK = 4;
  localparam int unsigned BASE = 8192;
  localparam int          TO   = 50;

  logic        clk = 1'b0;
  logic        reset, start, init_finish, sd_valid, tx_ready;
  logic [7:0]  sd_dout;

  logic        a_rd_req, a_tx_valid, a_busy, a_done, a_found, a_error;
  logic [31:0] a_block_address, a_match_addr;
  logic [7:0]  a_tx_data;
  logic        b_rd_req, b_tx_valid, b_busy, b_done, b_found, b_error;
  logic [31:0] b_block_address, b_match_addr;
  logic [7:0]  b_tx_data;

  sd_sig_scanner #(.MAX_BLOCKS(NBLK), .STOP_ON_NUL(1'b1), .TIMEOUT_CYCLES(TO)) dut_nul (
    .clk(clk), .reset(reset), .start(start), .init_finish(init_finish),
    .rd_req(a_rd_req), .block_address(a_block_address), .sd_dout(sd_dout),
    .sd_valid(sd_valid), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(tx_ready), .busy(a_busy), .done(a_done), .found(a_found),
    .match_addr(a_match_addr), .error(a_error));

  sd_sig_scanner #(.MAX_BLOCKS(NBLK), .STOP_ON_NUL(1'b0), .TIMEOUT_CYCLES(TO)) dut_full (
    .clk(clk), .reset(reset), .start(start), .init_finish(init_finish),
    .rd_req(b_rd_req), .block_address(b_block_address), .sd_dout(sd_dout),
    .sd_valid(sd_valid), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(tx_ready), .busy(b_busy), .done(b_done), .found(b_found),
    .match_addr(b_match_addr), .error(b_error));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sig [8] = '{8'h44, 8'h4C, 8'h41, 8'h42, 8'h5F, 8'h54, 8'h41, 8'h42};
  logic [7:0]  disk [NBLK][BB];
  int unsigned req_a[$], req_b[$];
  logic [7:0]  got_a[$], got_b[$];
  int          done_a, done_b, silent, silent_at_done;
  bit          seen_a, seen_b, hold_a, hold_b, first_after_start;
  logic [7:0]  hold_data_a, hold_data_b;
  logic        err_after_start;
  bit          rsp_active;
  int          rsp_idx, rsp_limit, valid_pct, ready_mode, ready_phase;
  int unsigned rsp_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] disk_byte(input int unsigned addr, input int idx);
    if (addr >= BASE && addr < BASE + NBLK) return disk[addr - BASE][idx];
    return 8'hFF;
  endfunction

  function automatic bit has_sig(input int k);
    for (int i = 0; i < 8; i++) if (disk[k][i] != sig[i]) return 1'b0;
    return 1'b1;
  endfunction

  // zero_rate 0: no NUL bytes; otherwise roughly one byte in zero_rate is 0x00.
  task automatic fill_block(input int k, input int zero_rate);
    for (int i = 0; i < BB; i++) begin
      disk[k][i] = 8'($urandom_range(255, 1));
      if (zero_rate > 0 && $urandom_range(zero_rate - 1) == 0) disk[k][i] = 8'h00;
    end
    if (disk[k][0] == sig[0]) disk[k][0] = 8'h45;
  endtask

  task automatic plant_sig(input int k);
    for (int i = 0; i < 8; i++) disk[k][i] = sig[i];
  endtask

  // One clock step: sample outputs at the falling edge, then drive the SD source and consumer.
  task automatic tick();
    bit junk;
    @(negedge clk);
    junk = 1'b0;
    if (a_rd_req === 1'b1) begin
      req_a.push_back(a_block_address);
      rsp_active = 1'b1; rsp_addr = a_block_address; rsp_idx = 0; silent = 0; junk = 1'b1;
    end
    if (b_rd_req === 1'b1) req_b.push_back(b_block_address);
    if (a_done === 1'b1) begin done_a++; silent_at_done = silent; end
    if (b_done === 1'b1) done_b++;
    if (first_after_start) begin err_after_start = a_error; first_after_start = 1'b0; end
    if (hold_a) begin
      check("hold_valid_nul", 32'(a_tx_valid), 32'd1);
      check("hold_data_nul", 32'(a_tx_data), 32'(hold_data_a));
    end
    if (hold_b) begin
      check("hold_valid_full", 32'(b_tx_valid), 32'd1);
      check("hold_data_full", 32'(b_tx_data), 32'(hold_data_b));
    end
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: begin tx_ready = (ready_phase == 2); ready_phase = (ready_phase + 1) % 3; end
      default: tx_ready = 1'($urandom_range(1));
    endcase
    if (a_tx_valid === 1'b1) seen_a = 1'b1;
    if (b_tx_valid === 1'b1) seen_b = 1'b1;
    if (a_tx_valid === 1'b1 && tx_ready) got_a.push_back(a_tx_data);
    if (b_tx_valid === 1'b1 && tx_ready) got_b.push_back(b_tx_data);
    hold_a = (a_tx_valid === 1'b1) && !tx_ready; hold_data_a = a_tx_data;
    hold_b = (b_tx_valid === 1'b1) && !tx_ready; hold_data_b = b_tx_data;
    if (junk) begin
      sd_valid = 1'b1; sd_dout = 8'hEE;  // lands while the DUT is still in REQ
    end else if (rsp_active && rsp_idx < rsp_limit && $urandom_range(99) < valid_pct) begin
      sd_valid = 1'b1; sd_dout = disk_byte(rsp_addr, rsp_idx);
      rsp_idx++; silent = 0;
      if (rsp_idx == BB) rsp_active = 1'b0;
    end else begin
      sd_valid = 1'b0; sd_dout = 8'($urandom);
      if (rsp_active) silent++;
    end
  endtask

  task automatic run_scan(input bit poke, input int budget);
    int n;
    req_a.delete(); req_b.delete(); got_a.delete(); got_b.delete();
    done_a = 0; done_b = 0; seen_a = 0; seen_b = 0; hold_a = 0; hold_b = 0;
    start = 1'b1; first_after_start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(a_busy), 32'd1);
    n = 0;
    while ((done_a == 0 || done_b == 0) && n < budget) begin
      if (poke && n == 300) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    check("scan_finished", 32'(done_a > 0 && done_b > 0), 32'd1);
    repeat (3) tick();
    check("done_pulses_nul", done_a, 1);
    check("done_pulses_full", done_b, 1);
  endtask

  task automatic expect_scan();
    int unsigned exp_req[$];
    logic [7:0]  exp_a[$], exp_b[$];
    bit          fnd, stopped;
    int unsigned maddr;
    int          k_hit, bad;
    fnd = 1'b0; stopped = 1'b0; maddr = 0; k_hit = 0;
    for (int k = 0; k < NBLK && !fnd; k++) begin
      exp_req.push_back(BASE + k);
      if (has_sig(k)) begin fnd = 1'b1; maddr = BASE + k; k_hit = k; end
    end
    if (fnd) begin
      for (int i = 0; i < BB; i++) begin
        exp_b.push_back(disk[k_hit][i]);
        if (disk[k_hit][i] == 8'h00) stopped = 1'b1;
        if (!stopped) exp_a.push_back(disk[k_hit][i]);
      end
    end
    check("req_count_nul", req_a.size(), exp_req.size());
    check("req_count_full", req_b.size(), exp_req.size());
    bad = 0;
    foreach (exp_req[i]) begin
      if (i >= req_a.size() || req_a[i] != exp_req[i]) bad++;
      if (i >= req_b.size() || req_b[i] != exp_req[i]) bad++;
    end
    check("req_addr_bad", bad, 0);
    check("found_nul", 32'(a_found), 32'(fnd));
    check("found_full", 32'(b_found), 32'(fnd));
    if (fnd) begin
      check("match_addr_nul", a_match_addr, maddr);
      check("match_addr_full", b_match_addr, maddr);
    end else begin
      check("tx_quiet_nul", 32'(seen_a), 32'd0);
      check("tx_quiet_full", 32'(seen_b), 32'd0);
    end
    check("tx_len_nul", got_a.size(), exp_a.size());
    check("tx_len_full", got_b.size(), exp_b.size());
    bad = 0;
    foreach (exp_a[i]) if (i >= got_a.size() || got_a[i] != exp_a[i]) bad++;
    foreach (exp_b[i]) if (i >= got_b.size() || got_b[i] != exp_b[i]) bad++;
    check("tx_bytes_bad", bad, 0);
    check("error_idle", 32'(a_error), 32'd0);
    check("busy_idle", 32'(a_busy), 32'd0);
  endtask

  initial begin
    int n, m;
    reset = 1'b0; init_finish = 1'b0; start = 1'b0; sd_valid = 1'b0; sd_dout = 8'h00;
    tx_ready = 1'b0; ready_mode = 0; ready_phase = 0; valid_pct = 100; rsp_limit = BB;
    rsp_active = 1'b0; rsp_idx = 0; rsp_addr = 0; silent = 0; silent_at_done = 0;
    first_after_start = 1'b0; err_after_start = 1'b0;
    hold_a = 1'b0; hold_b = 1'b0; hold_data_a = 8'h00; hold_data_b = 8'h00;
    repeat (2) tick();
    check("rst_rd_req", 32'(a_rd_req), 32'd0);
    check("rst_tx_valid", 32'(a_tx_valid), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_found", 32'(a_found), 32'd0);
    check("rst_error", 32'(a_error), 32'd0);
    check("rst_block_address", a_block_address, BASE);
    check("rst_match_addr", a_match_addr, 32'd0);

    // Start while sd_card is still initialising must be ignored.
    reset = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("init_no_req", req_a.size(), 0);
    check("init_not_busy", 32'(a_busy), 32'd0);
    init_finish = 1'b1;
    repeat (2) tick();

    // Signature in the last block, NUL at offset 20.
    for (int k = 0; k < NBLK; k++) fill_block(k, 0);
    plant_sig(3);
    disk[3][20] = 8'h00;
    run_scan(1'b0, 8000);
    expect_scan();
    check("nul_dump_len", got_a.size(), 20);

    // No match anywhere.
    for (int k = 0; k < NBLK; k++) fill_block(k, 32);
    ready_mode = 2; valid_pct = 80;
    run_scan(1'b0, 8000);
    expect_scan();

    // Near-miss in block 0, real match in block 1, 1-of-3 consumer, ignored mid-scan start.
    for (int k = 0; k < NBLK; k++) fill_block(k, 16);
    for (int i = 0; i < 7; i++) disk[0][i] = sig[i];
    disk[0][7] = 8'h41;
    plant_sig(1);
    ready_mode = 1; ready_phase = 0; valid_pct = 90;
    run_scan(1'b1, 8000);
    expect_scan();
    check("partial_match_addr", a_match_addr, BASE + 1);
    check("full_dump_len", got_b.size(), BB);

    // Randomised images, consumer and source pacing.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NBLK; k++) fill_block(k, 48);
      m = $urandom_range(NBLK);
      if (m < NBLK) plant_sig(m);
      ready_mode = 2; valid_pct = 60 + $urandom_range(40);
      run_scan(1'b0, 8000);
      expect_scan();
    end

    // Reset in the middle of READ, then a clean rescan.
    for (int k = 0; k < NBLK; k++) fill_block(k, 0);
    plant_sig(2);
    ready_mode = 0; valid_pct = 100;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (rsp_idx < 100 && n < 2000) begin tick(); n++; end
    check("mid_read_reached", 32'(rsp_idx >= 100), 32'd1);
    reset = 1'b0;
    tick();
    rsp_active = 1'b0;
    check("abort_rd_req", 32'(a_rd_req), 32'd0);
    check("abort_tx_valid", 32'(a_tx_valid), 32'd0);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_found", 32'(a_found), 32'd0);
    check("abort_block_address", a_block_address, BASE);
    reset = 1'b1;
    repeat (2) tick();
    run_scan(1'b0, 8000);
    expect_scan();

`ifdef SD_READ_TIMEOUT_EN
    // Source goes silent after 10 bytes of the (matching) first block.
    for (int k = 0; k < NBLK; k++) fill_block(k, 0);
    plant_sig(0);
    rsp_limit = 10; valid_pct = 100;
    run_scan(1'b0, 2000);
    check("to_error", 32'(a_error), 32'd1);
    check("to_found", 32'(a_found), 32'd0);
    check("to_silence", silent_at_done, TO);
    check("to_reqs", req_a.size(), 1);
    check("to_quiet", 32'(seen_a), 32'd0);
    rsp_limit = BB;
    run_scan(1'b0, 8000);
    check("to_err_cleared", 32'(err_after_start), 32'd0);
    expect_scan();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
